// File: rtl/jtopl_pg_sched.sv
// jtopl_pg_sched
// Time-multiplexed phase-generator sequencer for 18 operator slots
// (9 channels x 2 operators). Each cen tick issues one slot to the shared
// phase-increment datapath and, one tick later, accumulates the returned
// increment into that slot's 19-bit phase.
//
// Ports:
//   clk, rst (sync, active-high), cen (clock enable)
//   cfg_we/cfg_ch/cfg_fnum/cfg_block : channel config write (ch 0..8)
//   vib_en, vib_dep                  : per-slot vibrato enable, depth
//   phase_rst                        : per-slot phase clear, sampled at accumulate
//   pg_block/pg_fnum/pg_pm           : issued slot to increment datapath
//   phinc_pure                       : increment returned (comb. from pg_*)
//   phase_out/phase_slot/phase_valid : phase[18:9] of the slot just updated
//   frame_start                      : pulse on the tick that issues slot 0
module jtopl_pg_sched #(
    parameter int unsigned VIB_DIV_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_ch,
    input  logic [9:0]  cfg_fnum,
    input  logic [2:0]  cfg_block,
    input  logic [17:0] vib_en,
    input  logic        vib_dep,
    input  logic [17:0] phase_rst,
    output logic [2:0]  pg_block,
    output logic [9:0]  pg_fnum,
    output logic [3:0]  pg_pm,
    input  logic [17:0] phinc_pure,
    output logic [9:0]  phase_out,
    output logic [4:0]  phase_slot,
    output logic        phase_valid,
    output logic        frame_start
);

    localparam int unsigned NSLOT = 18;
    localparam int unsigned NCH   = 9;

    logic [9:0]           fnum_q  [NCH];
    logic [2:0]           block_q [NCH];
    logic [18:0]          phase_q [NSLOT];
    logic [4:0]           slot_q, slot_d;
    logic [4:0]           slot1_q;
    logic                 valid_q;
    logic [VIB_DIV_W-1:0] presc_q, presc_d;
    logic [2:0]           vib_cnt_q, vib_cnt_d;

    logic [2:0]           pg_block_q;
    logic [9:0]           pg_fnum_q;
    logic [3:0]           pg_pm_q;
    logic [9:0]           phase_out_q;
    logic [4:0]           phase_slot_q;
    logic                 phase_valid_q;
    logic                 frame_start_q;

    logic [3:0]           ch;
    logic [2:0]           vib_m;
    logic [2:0]           vib_mag;
    logic [3:0]           pm_d;
    logic [18:0]          acc_d;

    always_comb begin
        slot_d    = (slot_q == 5'd17) ? 5'd0 : slot_q + 5'd1;
        ch        = (slot_q < 5'd9) ? slot_q[3:0] : 4'(slot_q - 5'd9);

        // Prescaler counts frames; vib_cnt steps when it wraps.
        presc_d   = presc_q;
        vib_cnt_d = vib_cnt_q;
        if (slot_q == 5'd17) begin
            presc_d = presc_q + 1'b1;
            if (presc_q == '1)
                vib_cnt_d = vib_cnt_q + 3'd1;
        end

        // Vibrato: triangle over vib_cnt[1:0], sign from vib_cnt[2].
        vib_m = fnum_q[ch][9:7];
        case (vib_cnt_q[1:0])
            2'd0:    vib_mag = 3'd0;
            2'd2:    vib_mag = vib_m;
            default: vib_mag = vib_m >> 1;
        endcase
        if (!vib_dep)
            vib_mag = vib_mag >> 1;
        pm_d = '0;
        if (vib_en[slot_q])
            pm_d = vib_cnt_q[2] ? 4'd0 - {1'b0, vib_mag} : {1'b0, vib_mag};

        acc_d = phase_rst[slot1_q] ? '0 : phase_q[slot1_q] + {1'b0, phinc_pure};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                fnum_q[i]  <= '0;
                block_q[i] <= '0;
            end
            for (int unsigned i = 0; i < NSLOT; i++)
                phase_q[i] <= '0;
            slot_q        <= '0;
            slot1_q       <= '0;
            valid_q       <= 1'b0;
            presc_q       <= '0;
            vib_cnt_q     <= '0;
            pg_block_q    <= '0;
            pg_fnum_q     <= '0;
            pg_pm_q       <= '0;
            phase_out_q   <= '0;
            phase_slot_q  <= '0;
            phase_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // Config writes ignore cen; the issue below reads the pre-write value.
            if (cfg_we && cfg_ch < 4'd9) begin
                fnum_q[cfg_ch]  <= cfg_fnum;
                block_q[cfg_ch] <= cfg_block;
            end
            phase_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            if (cen) begin
                pg_fnum_q     <= fnum_q[ch];
                pg_block_q    <= block_q[ch];
                pg_pm_q       <= pm_d;
                slot1_q       <= slot_q;
                valid_q       <= 1'b1;
                slot_q        <= slot_d;
                frame_start_q <= (slot_q == 5'd0);
                presc_q       <= presc_d;
                vib_cnt_q     <= vib_cnt_d;
                if (valid_q) begin
                    phase_q[slot1_q] <= acc_d;
                    phase_out_q      <= acc_d[18:9];
                    phase_slot_q     <= slot1_q;
                    phase_valid_q    <= 1'b1;
                end
            end
        end
    end

    assign pg_block    = pg_block_q;
    assign pg_fnum     = pg_fnum_q;
    assign pg_pm       = pg_pm_q;
    assign phase_out   = phase_out_q;
    assign phase_slot  = phase_slot_q;
    assign phase_valid = phase_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_jtopl_pg_sched.sv
// Testbench for jtopl_pg_sched: stand-in increment datapath, reference
// model driven per tick, scoreboard queues for issue and phase results.
module tb_jtopl_pg_sched;

    localparam int VDW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = '0;
    logic [9:0]  cfg_fnum = '0;
    logic [2:0]  cfg_block = '0;
    logic [17:0] vib_en = '0;
    logic        vib_dep = 1'b0;
    logic [17:0] phase_rst = '0;
    logic [2:0]  pg_block;
    logic [9:0]  pg_fnum;
    logic [3:0]  pg_pm;
    logic [17:0] phinc_pure;
    logic [9:0]  phase_out;
    logic [4:0]  phase_slot;
    logic        phase_valid;
    logic        frame_start;

    jtopl_pg_sched #(.VIB_DIV_W(VDW)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_fnum(cfg_fnum), .cfg_block(cfg_block),
        .vib_en(vib_en), .vib_dep(vib_dep), .phase_rst(phase_rst),
        .pg_block(pg_block), .pg_fnum(pg_fnum), .pg_pm(pg_pm),
        .phinc_pure(phinc_pure),
        .phase_out(phase_out), .phase_slot(phase_slot),
        .phase_valid(phase_valid), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic int sx4(input int v);
        return ((v & 8) != 0) ? (v & 15) - 16 : (v & 15);
    endfunction

    // Stand-in datapath: ((2*fnum + pm) << block) / 2, 18 bits.
    function automatic int dp_phinc(input int f, input int b, input int pm);
        int x;
        x = ((2 * f + sx4(pm)) <<< b) >>> 1;
        return x & 'h3FFFF;
    endfunction

    function automatic int vib_pm(input int f, input int vc, input bit en, input bit dep);
        int m, mag;
        m = f >> 7;
        case (vc & 3)
            0:       mag = 0;
            2:       mag = m;
            default: mag = m / 2;
        endcase
        if (!dep) mag = mag / 2;
        if ((vc & 4) != 0) mag = -mag;
        if (!en) mag = 0;
        return mag & 15;
    endfunction

    always_comb phinc_pure = 18'(dp_phinc(int'(pg_fnum), int'(pg_block), int'(pg_pm)));

    typedef struct { int fnum; int block; int pm; } iss_t;
    typedef struct { int slot; int val; } phx_t;

    iss_t issue_q[$];
    phx_t ph_q[$];

    int errors = 0;
    int checks = 0;

    // Model state
    int m_n;
    int m_fnum[9];
    int m_block[9];
    int m_ph[18];
    bit m_pend;
    int m_pslot;
    int m_pphinc;
    int h_fnum, h_block, h_pm, h_pout, h_pslot;
    int last_s0, last_s1;
    bit wrap_seen;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit c, input bit r);
        iss_t ie;
        phx_t pe;
        int   s, chn, vc, nv, exp_fs, exp_pv;
        cen = c;
        rst = r;
        exp_fs = 0;
        if (r) begin
            m_n = 0;
            m_pend = 0;
            for (int i = 0; i < 18; i++) m_ph[i] = 0;
            for (int i = 0; i < 9; i++) begin m_fnum[i] = 0; m_block[i] = 0; end
            issue_q.delete();
            ph_q.delete();
            h_fnum = 0; h_block = 0; h_pm = 0; h_pout = 0; h_pslot = 0;
            last_s0 = 0; last_s1 = 0;
        end else begin
            if (c) begin
                if (m_pend) begin
                    nv = phase_rst[m_pslot] ? 0 : (m_ph[m_pslot] + m_pphinc) & 'h7FFFF;
                    m_ph[m_pslot] = nv;
                    pe.slot = m_pslot;
                    pe.val  = nv >> 9;
                    ph_q.push_back(pe);
                end
                s   = m_n % 18;
                chn = (s < 9) ? s : s - 9;
                vc  = ((m_n / 18) >> VDW) & 7;
                ie.fnum  = m_fnum[chn];
                ie.block = m_block[chn];
                ie.pm    = vib_pm(m_fnum[chn], vc, vib_en[s], vib_dep);
                issue_q.push_back(ie);
                m_pend   = 1;
                m_pslot  = s;
                m_pphinc = dp_phinc(ie.fnum, ie.block, ie.pm);
                exp_fs   = (s == 0) ? 1 : 0;
                m_n++;
            end
            if (cfg_we && int'(cfg_ch) < 9) begin
                m_fnum[cfg_ch]  = int'(cfg_fnum);
                m_block[cfg_ch] = int'(cfg_block);
            end
        end
        @(posedge clk);
        #1;
        chk("frame_start", int'(frame_start), exp_fs);
        if (c && !r && issue_q.size() > 0) begin
            ie = issue_q.pop_front();
            h_fnum = ie.fnum; h_block = ie.block; h_pm = ie.pm;
        end
        chk("pg_fnum", int'(pg_fnum), h_fnum);
        chk("pg_block", int'(pg_block), h_block);
        chk("pg_pm", int'(pg_pm), h_pm);
        exp_pv = (ph_q.size() > 0) ? 1 : 0;
        chk("phase_valid", int'(phase_valid), exp_pv);
        if (ph_q.size() > 0) begin
            pe = ph_q.pop_front();
            h_pout = pe.val;
            h_pslot = pe.slot;
        end
        chk("phase_out", int'(phase_out), h_pout);
        chk("phase_slot", int'(phase_slot), h_pslot);
        if (phase_valid && phase_slot == 5'd0) last_s0 = int'(phase_out);
        if (phase_valid && phase_slot == 5'd1) begin
            if (int'(phase_out) < last_s1) wrap_seen = 1'b1;
            last_s1 = int'(phase_out);
        end
        cfg_we = 1'b0;
    endtask

    task automatic cfg(input int ch, input int f, input int b);
        cfg_we    = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_fnum  = 10'(f);
        cfg_block = 3'(b);
    endtask

    task automatic run_to(input int k);
        while (m_n <= k) step(1'b1, 1'b0);
    endtask

    initial begin
        int t;
        // Reset state and idle frames with all fnum = 0
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("rst_pg_fnum", int'(pg_fnum), 0);
        step(1'b1, 1'b0);
        chk("fs_tick0", int'(frame_start), 1);
        step(1'b1, 1'b0);
        chk("pv_tick1", int'(phase_valid), 1);
        chk("pslot_tick1", int'(phase_slot), 0);
        run_to(40);

        // ch0 fnum=0x200 block=4: phase advances 0x2000 per visit
        step(1'b1, 1'b1);
        cfg(0, 'h200, 4);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("s0_frame1", last_s0, 'h010);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0);
        chk("s0_frame2", last_s0, 'h020);

        // Vibrato on slot 2
        step(1'b1, 1'b1);
        cfg(2, 'h380, 1);
        vib_en  = 18'h00004;
        vib_dep = 1'b1;
        step(1'b0, 1'b0);
        run_to(8 * 18 + 2);
        chk("pm_vc2_full", int'(pg_pm), 7);
        vib_dep = 1'b0;
        run_to(9 * 18 + 2);
        chk("pm_vc2_half", int'(pg_pm), 3);
        vib_dep = 1'b1;
        run_to(24 * 18 + 2);
        chk("pm_vc6_full", int'(pg_pm), 9);
        vib_en = '0;

        // Phase wrap on slot 1, then phase_rst on slot 0
        step(1'b1, 1'b1);
        cfg(1, 'h3FF, 7);
        step(1'b0, 1'b0);
        cfg(0, 'h200, 4);
        step(1'b0, 1'b0);
        wrap_seen = 1'b0;
        run_to(18 * 7);
        chk("wrap_seen", int'(wrap_seen), 1);
        phase_rst = 18'h00001;
        run_to(m_n + 17);
        chk("s0_phase_rst", last_s0, 0);
        phase_rst = '0;
        run_to(m_n + 17);
        chk("s0_after_rst", last_s0, 'h010);

        // Config write racing the slot 0 issue; ignored channel 12
        step(1'b1, 1'b1);
        cfg(0, 'h100, 2);
        step(1'b0, 1'b0);
        cfg(0, 'h155, 2);
        step(1'b1, 1'b0);
        chk("race_old", int'(pg_fnum), 'h100);
        run_to(9);
        chk("race_new", int'(pg_fnum), 'h155);
        cfg(12, 'h3FF, 7);
        step(1'b1, 1'b0);
        run_to(18);
        chk("ch12_ignored", int'(pg_fnum), 'h155);

        // Reset in flight at slot 7, then restart
        t = m_n - (m_n % 18) + 7;
        if (t < m_n) t += 18;
        run_to(t);
        step(1'b1, 1'b1);
        chk("midrst_pv", int'(phase_valid), 0);
        chk("midrst_pout", int'(phase_out), 0);
        step(1'b1, 1'b0);
        chk("restart_fs", int'(frame_start), 1);

        // cen low for 5 clocks mid-frame
        cfg(3, 'h2AA, 3);
        step(1'b0, 1'b0);
        run_to(5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        run_to(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtopl_pg_sched.md
Name: jtopl_pg_sched

Overview:
- Time-multiplexed phase-generator sequencer for the 18 operator slots (9 channels × 2 operators).
- On each clock-enabled tick it:
  - steps the slot counter;
  - drives block, fnum and vibrato PM offset for the current slot into the shared phase-increment datapath;
  - takes the returned phinc_pure one tick later and accumulates it into an 18-entry phase memory.
- Sits between the channel register file and the operator/envelope pipeline.

Parameters:
- VIB_DIV_W, 10, width of the frame prescaler; the vibrato step advances every 2^VIB_DIV_W frames.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  clock enable; all state advances only when cen=1
- cfg_we  in  1  write strobe for the channel config
- cfg_ch  in  4  channel index 0..8; values 9..15 are ignored
- cfg_fnum  in  10  F-number to store
- cfg_block  in  3  block (octave) to store
- vib_en  in  18  per-slot vibrato enable
- vib_dep  in  1  vibrato depth: 1 = full, 0 = half
- phase_rst  in  18  per-slot phase clear (level)
- pg_block  out  3  block to the increment datapath
- pg_fnum  out  10  fnum to the increment datapath
- pg_pm  out  4  signed PM offset to the increment datapath
- phinc_pure  in  18  increment returned by the datapath (combinational from pg_*)
- phase_out  out  10  phase[18:9] of the slot just updated
- phase_slot  out  5  slot index of phase_out
- phase_valid  out  1  one-clk pulse when phase_out/phase_slot update
- frame_start  out  1  one-clk pulse on the cen tick that issues slot 0

Behaviour:
- Reset (clk edge with rst=1) clears the following; reset mid-frame discards the in-flight slot and no write-back occurs:
  - slot counter to 0;
  - all config regs (fnum=0, block=0);
  - all 18 × 19-bit phase entries to 0;
  - frame prescaler and vib_cnt (3-bit) to 0;
  - pipeline valid bit to 0;
  - all outputs to 0.
- Slot mapping: ch = (s<9) ? s : s-9.
- Stage 0, issue, on a cen tick with slot s:
  - pg_fnum and pg_block are registered from config[ch];
  - pg_pm is registered as the vibrato offset;
  - the issued slot index is stored and the pipeline valid bit set;
  - s becomes (s==17) ? 0 : s+1;
  - frame_start=1 when the issued s==0.
- Vibrato offset:
  - m = fnum[9:7];
  - p = vib_cnt[1:0]: p=0 gives 0; p=1 or 3 gives m>>1; p=2 gives m;
  - when vib_dep=0 the magnitude is shifted right by 1 more;
  - the magnitude is negated when vib_cnt[2]=1;
  - the result is 0 when vib_en[s]=0;
  - range is -7..+7.
- Stage 1, accumulate, on the next cen tick when the pipeline is valid (runs concurrently with the next issue):
  - new = phase_rst[slot] ? 0 : (phase[slot] + {1'b0,phinc_pure}) mod 2^19;
  - new is written to phase[slot];
  - phase_out = new[18:9];
  - phase_slot = slot;
  - phase_valid = 1 for that clk, 0 otherwise.
- Latency: 2 cen ticks from issue to phase_out.
- Frame counting:
  - on the issue of slot 17, the prescaler increments;
  - when the prescaler wraps from 2^VIB_DIV_W-1 to 0, vib_cnt increments (wraps 7→0).
- Config write: on cen or not, a cfg_we edge with cfg_ch<9 updates config[cfg_ch].
  - A write in the same cycle as an issue from that channel: the issue uses the old value; the new value applies from the next issue.
- cen=0:
  - no state changes except config writes;
  - phase_valid and frame_start are 0;
  - pg_*, phase_out and phase_slot hold.
- phase_rst is sampled at stage 1 only; a slot held in phase_rst stays at 0.

Test Plan:
- Reset, then cen=1 continuously → frame_start every 18 cen ticks, first at tick 0; phase_valid first at tick 1 with phase_slot=0; phase_out=0 while all fnum=0.
- ch0 fnum=0x200, block=4, vib_en=0 → phinc_pure=0x2000 for slots 0 and 9; after frame 1, slot 0 phase_out=0x010; after frame 2, 0x020. Slots 1..8 remain 0.
- ch2 fnum=0x380, vib_en[2]=1, vib_dep=1, vib_cnt forced to 2 via 2×2^VIB_DIV_W frames → pg_pm=+7 at the slot 2 issue. At vib_cnt=6 → pg_pm=-7 (4'b1001). With vib_dep=0 at vib_cnt=2 → pg_pm=+3.
- Phase wrap: fnum=0x3FF, block=7 with phase near 2^19 → phase wraps modulo 2^19 with no saturation. Asserting phase_rst[0] → the next slot 0 phase_out=0.
- cfg_we to ch0 on the exact cycle slot 0 issues → pg_fnum shows the old value; the slot 9 issue shows the new value. cfg_ch=12 → no config change.
- rst asserted mid-frame at slot 7 → the next clk shows all outputs 0, no phase_valid for the in-flight slot, and restart from slot 0. cen low for 5 clks mid-frame → outputs hold, no pulses.
